i2c_bus_frontend: RTL and testbench
===================================

I2C_BUS_FRONTEND -- requirements
Module: i2c_bus_frontend

Interface
REQ-001 SHALL have parameter NUM_CH, default 1, number of independent SCL/SDA channel pairs (1..8).
REQ-002 SHALL have parameter FILT_LEN, default 3, stable-cycle count required before a filtered line changes (1..15).
REQ-003 SHALL have parameter TO_CYCLES, default 1024, SCL-low timeout threshold in clk cycles (16..65535).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 scl_out  in  NUM_CH  per-channel SCL drive value.
REQ-008 scl_oen  in  NUM_CH  per-channel SCL output enable, active-high.
REQ-009 sda_out  in  NUM_CH  per-channel SDA drive value.
REQ-010 sda_oen  in  NUM_CH  per-channel SDA output enable, active-high.
REQ-011 scl_pad  inout  NUM_CH  open-drain SCL line, externally pulled up.
REQ-012 sda_pad  inout  NUM_CH  open-drain SDA line, externally pulled up.
REQ-013 scl_in  out  NUM_CH  synchronised, glitch-filtered SCL.
REQ-014 sda_in  out  NUM_CH  synchronised, glitch-filtered SDA.
REQ-015 start_det  out  NUM_CH  one-cycle pulse on START or repeated START.
REQ-016 stop_det  out  NUM_CH  one-cycle pulse on STOP.
REQ-017 bus_busy  out  NUM_CH  level, high between START and STOP.
REQ-018 arb_lost  out  NUM_CH  one-cycle pulse on lost SDA arbitration.
REQ-019 timeout  out  NUM_CH  one-cycle pulse on SCL-low timeout.

Function
REQ-020 Pad drive SHALL be true open-drain: pad[i] driven 0 only when oen[i]===1 and out[i]===0; otherwise z. An X or Z on oen or out SHALL release the line.
REQ-021 Each pad SHALL pass through a 2-flop synchroniser; Z/X sampled values SHALL be treated as 1.
REQ-022 Filter: per line, a counter counts consecutive cycles where the synchronised value differs from the filtered output; on reaching FILT_LEN, the filtered output takes the new value and the counter clears; any agreeing cycle clears the counter.
REQ-023 Latency from a clean pad edge to scl_in/sda_in change SHALL be exactly 2+FILT_LEN cycles; pulses of at most FILT_LEN-1 cycles SHALL never propagate.
REQ-024 START: filtered SDA falls while filtered SCL is 1 in both the previous and current cycle; start_det pulses the following cycle.
REQ-025 STOP: filtered SDA rises under the same SCL condition; stop_det pulses the following cycle.
REQ-026 Filtered SCL and SDA changing in the same cycle SHALL produce neither START nor STOP.
REQ-027 bus_busy SHALL set on START and clear on STOP; START while busy (repeated START) SHALL pulse start_det with bus_busy held high.
REQ-028 Arbitration: on a filtered SCL 0->1 edge, if sda_oen===1, sda_out===1 and filtered SDA==0, arb_lost SHALL pulse the following cycle.
REQ-029 Channels SHALL be fully independent; no state is shared.

Reset
REQ-030 While rst high: scl_in=1, sda_in=1, synchroniser and filter state =1, counters=0, start_det=stop_det=arb_lost=timeout=0, bus_busy=0.
REQ-031 Reset asserted mid-transfer SHALL abort all detection immediately; after release, the first START requires a fresh SDA fall from a filtered-high state.
REQ-032 Pad drive (REQ-020) SHALL stay combinational and unaffected by rst.

Configuration
REQ-033 Macro I2C_BUS_TIMEOUT_EN defined: per-channel counter increments while bus_busy=1 and filtered SCL=0, clears when SCL=1 or on rst; on reaching TO_CYCLES, timeout pulses one cycle, bus_busy clears, and the counter holds until SCL goes high.
REQ-034 Macro undefined: no timeout counter is synthesised; timeout SHALL be tied 0 and bus_busy clears only on STOP or rst.

Verification
REQ-035 NUM_CH=1, FILT_LEN=3: sda_oen=1, sda_out=0 -> sda_pad=0; sda_oen=1'bx -> sda_pad=z; pulled-up sda_in reads 1.
REQ-036 2-cycle SDA low glitch on idle bus -> sda_in stays 1, no start_det; 3-cycle low -> sda_in falls exactly 5 cycles after pad edge.
REQ-037 START, 9 SCL clocks, repeated START, STOP -> start_det pulses twice, stop_det once, bus_busy high from first START until STOP.
REQ-038 Drive sda_out=1, sda_oen=1 while second driver holds sda_pad=0 across an SCL rise -> arb_lost single-cycle pulse.
REQ-039 I2C_BUS_TIMEOUT_EN, TO_CYCLES=16: START then SCL held low 20 cycles -> timeout pulses once at count 16, bus_busy falls; without macro, timeout stays 0 and bus_busy stays 1.
REQ-040 NUM_CH=4: START on channel 2, rst asserted mid-byte -> all outputs return to reset values asynchronously; channels 0,1,3 never pulse.

Source files
------------

// File: rtl/i2c_bus_frontend.sv
// Per-channel I2C pad front end: open-drain drive, 2-flop sync, glitch filter,
// START/STOP/arbitration detection. Define I2C_BUS_TIMEOUT_EN for the SCL-low timeout.
module i2c_bus_frontend #(
    parameter int NUM_CH    = 1,
    parameter int FILT_LEN  = 3,
    parameter int TO_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] scl_out,
    input  logic [NUM_CH-1:0] scl_oen,
    input  logic [NUM_CH-1:0] sda_out,
    input  logic [NUM_CH-1:0] sda_oen,
    inout  wire  [NUM_CH-1:0] scl_pad,
    inout  wire  [NUM_CH-1:0] sda_pad,
    output logic [NUM_CH-1:0] scl_in,
    output logic [NUM_CH-1:0] sda_in,
    output logic [NUM_CH-1:0] start_det,
    output logic [NUM_CH-1:0] stop_det,
    output logic [NUM_CH-1:0] bus_busy,
    output logic [NUM_CH-1:0] arb_lost,
    output logic [NUM_CH-1:0] timeout
);
    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);

    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("NUM_CH out of range 1..8");
    end
    if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("FILT_LEN out of range 1..15");
    end
    if (TO_CYCLES < 16 || TO_CYCLES > 65535) begin : g_bad_to_cycles
        $error("TO_CYCLES out of range 16..65535");
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        // Line index 0 is SCL, 1 is SDA throughout.
        logic [1:0]      raw;
        logic [1:0]      sync1_q, sync2_q, filt_q, filt_d, prev_q;
        logic [1:0][3:0] cnt_q, cnt_d;
        logic            start_d, stop_d, arb_d, busy_d, to_hit;
        logic            start_q, stop_q, arb_q, busy_q, to_q;

        assign scl_pad[ch] = (scl_oen[ch] === 1'b1 && scl_out[ch] === 1'b0) ? 1'b0 : 1'bz;
        assign sda_pad[ch] = (sda_oen[ch] === 1'b1 && sda_out[ch] === 1'b0) ? 1'b0 : 1'bz;

        assign raw = {(sda_pad[ch] === 1'b0) ? 1'b0 : 1'b1,
                      (scl_pad[ch] === 1'b0) ? 1'b0 : 1'b1};

        always_comb begin
            filt_d = filt_q;
            cnt_d  = '0;
            for (int unsigned l = 0; l < 2; l++) begin
                if (sync2_q[l] != filt_q[l]) begin
                    if (cnt_q[l] == FILT_MAX) filt_d[l] = sync2_q[l];
                    else                      cnt_d[l]  = cnt_q[l] + 4'd1;
                end
            end
        end

        // SCL must be high in both cycles, so simultaneous SCL/SDA changes are ignored.
        always_comb begin
            start_d = prev_q[0] & filt_q[0] &  prev_q[1] & ~filt_q[1];
            stop_d  = prev_q[0] & filt_q[0] & ~prev_q[1] &  filt_q[1];
            arb_d   = ~prev_q[0] & filt_q[0] & ~filt_q[1]
                    & (sda_oen[ch] === 1'b1) & (sda_out[ch] === 1'b1);
            busy_d  = busy_q;
            if (start_d)                busy_d = 1'b1;
            else if (stop_d || to_hit)  busy_d = 1'b0;
        end

`ifdef I2C_BUS_TIMEOUT_EN
        localparam logic [15:0] TO_MAX = 16'(TO_CYCLES);
        logic [15:0] to_cnt_q, to_cnt_d;

        always_comb begin
            to_cnt_d = to_cnt_q;
            if (filt_q[0])                          to_cnt_d = '0;
            else if (busy_q && to_cnt_q != TO_MAX)  to_cnt_d = to_cnt_q + 16'd1;
        end

        assign to_hit = (to_cnt_d == TO_MAX) && (to_cnt_q != TO_MAX);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) to_cnt_q <= '0;
            else     to_cnt_q <= to_cnt_d;
        end
`else
        assign to_hit = 1'b0;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q <= '1;
                sync2_q <= '1;
                filt_q  <= '1;
                prev_q  <= '1;
                cnt_q   <= '0;
                start_q <= 1'b0;
                stop_q  <= 1'b0;
                arb_q   <= 1'b0;
                busy_q  <= 1'b0;
                to_q    <= 1'b0;
            end else begin
                sync1_q <= raw;
                sync2_q <= sync1_q;
                filt_q  <= filt_d;
                prev_q  <= filt_q;
                cnt_q   <= cnt_d;
                start_q <= start_d;
                stop_q  <= stop_d;
                arb_q   <= arb_d;
                busy_q  <= busy_d;
                to_q    <= to_hit;
            end
        end

        assign scl_in[ch]    = filt_q[0];
        assign sda_in[ch]    = filt_q[1];
        assign start_det[ch] = start_q;
        assign stop_det[ch]  = stop_q;
        assign arb_lost[ch]  = arb_q;
        assign bus_busy[ch]  = busy_q;
        assign timeout[ch]   = to_q;
    end

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Self-checking bench for i2c_bus_frontend: sliding-window filter model compared every cycle,
// plus directed I2C sequences with hand-computed expectations.
module tb_i2c_bus_frontend;
    localparam int NCH = 4;
    localparam int FL  = 3;
    localparam int TO  = 16;
    localparam int P   = 6;
`ifdef I2C_BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] scl_out, scl_oen, sda_out, sda_oen;
    logic [NCH-1:0] scl_ext, sda_ext;
    wire  [NCH-1:0] scl_pad, sda_pad;
    logic [NCH-1:0] scl_in, sda_in, start_det, stop_det, bus_busy, arb_lost, timeout;

    int checks   = 0;
    int failures = 0;

    for (genvar i = 0; i < NCH; i++) begin : g_pad
        assign scl_pad[i] = scl_ext[i] ? 1'b0 : 1'bz;
        assign sda_pad[i] = sda_ext[i] ? 1'b0 : 1'bz;
        pullup pu_scl (scl_pad[i]);
        pullup pu_sda (sda_pad[i]);
    end

    i2c_bus_frontend #(.NUM_CH(NCH), .FILT_LEN(FL), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .scl_out(scl_out), .scl_oen(scl_oen), .sda_out(sda_out), .sda_oen(sda_oen),
        .scl_pad(scl_pad), .sda_pad(sda_pad),
        .scl_in(scl_in), .sda_in(sda_in), .start_det(start_det), .stop_det(stop_det),
        .bus_busy(bus_busy), .arb_lost(arb_lost), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: pad history per line; a filtered line flips once the FL samples seen
    // through the two sync stages all disagree with it.
    logic [16:0]    hist [NCH][2];
    logic [1:0]     mf [NCH];
    logic [1:0]     mp [NCH];
    int             tc [NCH];
    logic [NCH-1:0] m_start, m_stop, m_arb, m_to, m_busy, m_scl, m_sda;
    logic [1:0]     pv;
    logic           flip;
    int             cyc_n = 0;
    int             fall_cyc = 0;
    logic           prev_sda0 = 1'b1;
    int             n_start [NCH];
    int             n_stop  [NCH];
    int             n_arb   [NCH];
    int             n_to    [NCH];

    initial begin
        for (int c = 0; c < NCH; c++) begin
            n_start[c] = 0; n_stop[c] = 0; n_arb[c] = 0; n_to[c] = 0;
        end
    end

    always @(posedge clk) begin
        cyc_n++;
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                hist[c][0] = '1; hist[c][1] = '1;
                mf[c] = 2'b11; mp[c] = 2'b11; tc[c] = 0;
                m_start[c] = 1'b0; m_stop[c] = 1'b0; m_arb[c] = 1'b0;
                m_to[c] = 1'b0; m_busy[c] = 1'b0;
            end else begin
                pv[0] = !(scl_ext[c] || (scl_oen[c] === 1'b1 && scl_out[c] === 1'b0));
                pv[1] = !(sda_ext[c] || (sda_oen[c] === 1'b1 && sda_out[c] === 1'b0));
                m_start[c] = mp[c][1] & ~mf[c][1] & mp[c][0] & mf[c][0];
                m_stop[c]  = ~mp[c][1] & mf[c][1] & mp[c][0] & mf[c][0];
                m_arb[c]   = ~mp[c][0] & mf[c][0] & ~mf[c][1]
                           & (sda_oen[c] === 1'b1) & (sda_out[c] === 1'b1);
                m_to[c] = 1'b0;
                if (mf[c][0]) tc[c] = 0;
                else if (TO_EN && m_busy[c] && tc[c] < TO) begin
                    tc[c]++;
                    m_to[c] = (tc[c] == TO);
                end
                if (m_start[c])                  m_busy[c] = 1'b1;
                else if (m_stop[c] || m_to[c])   m_busy[c] = 1'b0;
                mp[c] = mf[c];
                for (int l = 0; l < 2; l++) begin
                    hist[c][l] = {hist[c][l][15:0], pv[l]};
                    flip = 1'b1;
                    for (int k = 2; k < FL + 2; k++)
                        if (hist[c][l][k] == mf[c][l]) flip = 1'b0;
                    if (flip) mf[c][l] = ~mf[c][l];
                end
            end
            m_scl[c] = mf[c][0];
            m_sda[c] = mf[c][1];
        end
        #1;
        chk("scl_in",    scl_in,    m_scl);
        chk("sda_in",    sda_in,    m_sda);
        chk("start_det", start_det, m_start);
        chk("stop_det",  stop_det,  m_stop);
        chk("arb_lost",  arb_lost,  m_arb);
        chk("timeout",   timeout,   m_to);
        chk("bus_busy",  bus_busy,  m_busy);
        for (int c = 0; c < NCH; c++) begin
            n_start[c] += int'(start_det[c]);
            n_stop[c]  += int'(stop_det[c]);
            n_arb[c]   += int'(arb_lost[c]);
            n_to[c]    += int'(timeout[c]);
        end
        if (prev_sda0 && !sda_in[0]) fall_cyc = cyc_n;
        prev_sda0 = sda_in[0];
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int s0, p0, a0, t0, k0, oth0, oth1;
    logic [8:0] bits;

    initial begin
        rst = 1'b1;
        scl_out = '0; scl_oen = '0; sda_out = '0; sda_oen = '0;
        scl_ext = '0; sda_ext = '0;
        #1;
        chk("rst_scl_in", scl_in, '1);
        chk("rst_sda_in", sda_in, '1);
        chk("rst_start",  start_det, '0);
        chk("rst_busy",   bus_busy, '0);
        w(3);
        rst = 1'b0;
        w(4);

        // Open-drain pad drive, X on enable releases.
        sda_oen[0] = 1'b1; sda_out[0] = 1'b0;
        #1 chk("pad_drive_low", {3'b0, sda_pad[0]}, 4'b0000);
        sda_oen[0] = 1'bx;
        #1 chk("pad_x_release", {3'b0, sda_pad[0]}, 4'b0001);
        sda_oen[0] = 1'b0; sda_out[0] = 1'b1;
        w(8);
        chk("sda_in_idle", sda_in, 4'b1111);

        // 2-cycle glitch suppressed; 3-cycle pulse passes with latency 5.
        s0 = n_start[0]; p0 = n_stop[0];
        sda_ext[0] = 1'b1; w(2); sda_ext[0] = 1'b0; w(10);
        chk_i("glitch_no_start", n_start[0] - s0, 0);
        chk_i("glitch_no_fall",  fall_cyc, 0);
        k0 = cyc_n;
        sda_ext[0] = 1'b1; w(3); sda_ext[0] = 1'b0; w(12);
        chk_i("sda_latency",     fall_cyc - k0, 5);
        chk_i("pulse_start_cnt", n_start[0] - s0, 1);
        chk_i("pulse_stop_cnt",  n_stop[0] - p0, 1);

        // START, 9 clocks, repeated START, STOP.
        s0 = n_start[0]; p0 = n_stop[0];
        bits = 9'b101100101;
        sda_ext[0] = 1'b1; w(P);
        chk("busy_after_start", bus_busy, 4'b0001);
        scl_ext[0] = 1'b1; w(P);
        for (int i = 0; i < 9; i++) begin
            sda_ext[0] = ~bits[i]; w(P);
            scl_ext[0] = 1'b0;     w(P);
            scl_ext[0] = 1'b1;     w(P);
        end
        chk("busy_mid_byte", bus_busy, 4'b0001);
        sda_ext[0] = 1'b0; w(P);
        scl_ext[0] = 1'b0; w(P);
        sda_ext[0] = 1'b1; w(P);
        chk_i("rep_start_cnt", n_start[0] - s0, 2);
        chk("busy_rep_start", bus_busy, 4'b0001);
        scl_ext[0] = 1'b1; w(P);
        scl_ext[0] = 1'b0; w(P);
        sda_ext[0] = 1'b0; w(P + 2);
        chk_i("stop_cnt", n_stop[0] - p0, 1);
        chk("busy_after_stop", bus_busy, 4'b0000);

        // Arbitration: we release SDA high, another driver holds it low across SCL rise.
        sda_ext[0] = 1'b1; w(P);
        scl_ext[0] = 1'b1; w(P);
        sda_oen[0] = 1'b1; sda_out[0] = 1'b1; w(P);
        a0 = n_arb[0];
        scl_ext[0] = 1'b0; w(P);
        chk_i("arb_lost_cycles", n_arb[0] - a0, 1);
        scl_ext[0] = 1'b1; w(P);
        sda_oen[0] = 1'b0; sda_out[0] = 1'b0;
        scl_ext[0] = 1'b0; w(P);
        sda_ext[0] = 1'b0; w(P + 2);
        chk("busy_after_arb", bus_busy, 4'b0000);

        // SCL held low after START.
        sda_ext[0] = 1'b1; w(P);
        scl_ext[0] = 1'b1; t0 = n_to[0]; w(26);
        chk_i("timeout_pulses", n_to[0] - t0, TO_EN ? 1 : 0);
        chk("busy_after_to", bus_busy, TO_EN ? 4'b0000 : 4'b0001);
        scl_ext[0] = 1'b0; w(P);
        sda_ext[0] = 1'b0; w(P + 2);
        chk("busy_idle", bus_busy, 4'b0000);

        // Channel 2 transfer aborted by asynchronous reset.
        oth0 = n_start[0] + n_start[1] + n_start[3] + n_stop[0] + n_stop[1] + n_stop[3]
             + n_arb[0] + n_arb[1] + n_arb[3] + n_to[0] + n_to[1] + n_to[3];
        sda_ext[2] = 1'b1; w(P);
        scl_ext[2] = 1'b1; w(P);
        sda_ext[2] = 1'b0; w(3);
        chk("ch2_busy", bus_busy, 4'b0100);
        #3 rst = 1'b1;
        #1;
        chk("async_scl_in", scl_in, '1);
        chk("async_sda_in", sda_in, '1);
        chk("async_busy",   bus_busy, '0);
        chk("async_pulses", start_det | stop_det | arb_lost | timeout, '0);
        scl_ext = '0; sda_ext = '0;
        w(3);
        rst = 1'b0;
        w(P + 4);
        oth1 = n_start[0] + n_start[1] + n_start[3] + n_stop[0] + n_stop[1] + n_stop[3]
             + n_arb[0] + n_arb[1] + n_arb[3] + n_to[0] + n_to[1] + n_to[3];
        chk_i("other_ch_quiet", oth1 - oth0, 0);
        chk("busy_post_rst", bus_busy, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
